// File: rtl/nucore_pipe.sv
// Three-stage (IF / ID / EX) micro-core with a 3-bit opcode ISA and an internal instruction memory.
// Latency: the first result appears on `result` 3 clocks after the start edge, then one instruction retires per RUN cycle.
// Backpressure: none. The pipeline advances every RUN cycle, or only on step=1 cycles when NUCORE_STEP_EN is defined.
//
// Optional feature macro: NUCORE_STEP_EN (adds the `step` input).
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   imem_we/addr/wdata    instruction-memory write port, honoured only in IDLE or HALTED
//   start                 one-cycle pulse; (re)starts execution at address 0 from IDLE or HALTED
//   result, z_flag        last LOADI/ALU result, and a zero flag for ALU ops only
//   busy, halted          FSM is in RUN / HALTED
//   pc                    current fetch address
//   step (optional)       single-step enable for the pipeline while in RUN
//
// Instruction format (MSB to LSB): op[3] | rd | ra | rb | imm[DATA_W]
module nucore_pipe #(
    parameter int  DATA_W  = 32,
    parameter int  REG_AW  = 4,
    parameter int  IMEM_AW = 6,
    localparam int INST_W  = 3 + 3*REG_AW + DATA_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_addr,
    input  logic [INST_W-1:0]  imem_wdata,
    input  logic               start,
    output logic [DATA_W-1:0]  result,
    output logic               z_flag,
    output logic               busy,
    output logic               halted,
    output logic [IMEM_AW-1:0] pc
`ifdef NUCORE_STEP_EN
    ,
    input  logic               step
`endif
);

    localparam int NREG  = 1 << REG_AW;
    localparam int NWORD = 1 << IMEM_AW;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOADI = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [IMEM_AW-1:0]   pc_q, pc_d;

    logic                 if_vld_q, if_vld_d;
    logic [INST_W-1:0]    if_inst_q, if_inst_d;

    logic                 ex_vld_q, ex_vld_d;
    logic [2:0]           ex_op_q, ex_op_d;
    logic [REG_AW-1:0]    ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0]    ex_a_q, ex_a_d;   // holds the immediate for LOADI
    logic [DATA_W-1:0]    ex_b_q, ex_b_d;

    logic [DATA_W-1:0]    result_q, result_d;
    logic                 z_flag_q, z_flag_d;

    logic [DATA_W-1:0]    rf_q [NREG];
    logic [DATA_W-1:0]    rf_d [NREG];

    // Instruction memory: deliberately outside the reset domain so a
    // program survives reset_n.
    logic [INST_W-1:0]    imem_mem [NWORD];

    // ------------------------------------------------------------------
    // Control qualifiers
    // ------------------------------------------------------------------
    logic run;
    logic adv;        // pipeline moves forward this cycle
    logic enter_run;  // start accepted; start is ignored while already running
    logic id_halt;    // HALT sits in ID and the pipeline advances

    assign run       = (state_q == S_RUN);
`ifdef NUCORE_STEP_EN
    assign adv       = run && step;
`else
    assign adv       = run;
`endif
    assign enter_run = start && (state_q != S_RUN);

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    logic [2:0]        id_op;
    logic [REG_AW-1:0] id_rd, id_ra, id_rb;
    logic [DATA_W-1:0] id_imm;

    assign id_op  = if_inst_q[INST_W-1 -: 3];
    assign id_rd  = if_inst_q[INST_W-4 -: REG_AW];
    assign id_ra  = if_inst_q[INST_W-4-REG_AW -: REG_AW];
    assign id_rb  = if_inst_q[INST_W-4-2*REG_AW -: REG_AW];
    assign id_imm = if_inst_q[DATA_W-1:0];

    assign id_halt = adv && if_vld_q && (id_op == OP_HALT);

    // ------------------------------------------------------------------
    // EX: ALU and writeback qualifiers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ex_res;
    logic              ex_wr;     // valid LOADI or ALU op in EX
    logic              ex_is_alu; // ADD..XOR, the only ops that touch z_flag

    always_comb begin
        ex_res = ex_a_q;
        unique case (ex_op_q)
            OP_ADD:  ex_res = ex_a_q + ex_b_q;
            OP_SUB:  ex_res = ex_a_q - ex_b_q;
            OP_AND:  ex_res = ex_a_q & ex_b_q;
            OP_OR:   ex_res = ex_a_q | ex_b_q;
            OP_XOR:  ex_res = ex_a_q ^ ex_b_q;
            default: ex_res = ex_a_q;
        endcase
    end

    assign ex_is_alu = (ex_op_q >= OP_ADD) && (ex_op_q <= OP_XOR);
    assign ex_wr     = ex_vld_q && (ex_is_alu || (ex_op_q == OP_LOADI));

    // The instruction in EX has not been written back yet, so ID takes its
    // result directly instead of the stale register-file entry.
    logic [DATA_W-1:0] id_opa, id_opb;

    always_comb begin
        id_opa = rf_q[id_ra];
        id_opb = rf_q[id_rb];
        if (ex_wr && (ex_rd_q == id_ra)) id_opa = ex_res;
        if (ex_wr && (ex_rd_q == id_rb)) id_opb = ex_res;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start)   state_d = S_RUN;
            S_RUN:    if (id_halt) state_d = S_HALTED;
            S_HALTED: if (start)   state_d = S_RUN;
            default:               state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = 1'b0;
        halted = 1'b0;
        unique case (state_q)
            S_RUN:    busy   = 1'b1;
            S_HALTED: halted = 1'b1;
            default: begin
                busy   = 1'b0;
                halted = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d      = pc_q;
        if_vld_d  = if_vld_q;
        if_inst_d = if_inst_q;
        ex_vld_d  = ex_vld_q;
        ex_op_d   = ex_op_q;
        ex_rd_d   = ex_rd_q;
        ex_a_d    = ex_a_q;
        ex_b_d    = ex_b_q;
        result_d  = result_q;
        z_flag_d  = z_flag_q;
        rf_d      = rf_q;

        if (enter_run) begin
            // Restart from address 0 with an empty pipeline.
            pc_d     = '0;
            if_vld_d = 1'b0;
            ex_vld_d = 1'b0;
        end else if (adv) begin
            // Writeback. This also happens on the halting edge, so the
            // instruction already in EX always completes.
            if (ex_wr) begin
                rf_d[ex_rd_q] = ex_res;
                result_d      = ex_res;
                if (ex_is_alu) z_flag_d = (ex_res == '0);
            end

            if (id_halt) begin
                // Squash the fetch behind HALT and freeze pc. HALT itself
                // does not enter EX.
                if_vld_d = 1'b0;
                ex_vld_d = 1'b0;
            end else begin
                if_inst_d = imem_mem[pc_q];
                if_vld_d  = 1'b1;
                pc_d      = pc_q + IMEM_AW'(1);   // wraps naturally

                ex_vld_d  = if_vld_q;
                ex_op_d   = id_op;
                ex_rd_d   = id_rd;
                ex_a_d    = (id_op == OP_LOADI) ? id_imm : id_opa;
                ex_b_d    = id_opb;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= '0;
            if_vld_q  <= 1'b0;
            if_inst_q <= '0;
            ex_vld_q  <= 1'b0;
            ex_op_q   <= OP_NOP;
            ex_rd_q   <= '0;
            ex_a_q    <= '0;
            ex_b_q    <= '0;
            result_q  <= '0;
            z_flag_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            if_vld_q  <= if_vld_d;
            if_inst_q <= if_inst_d;
            ex_vld_q  <= ex_vld_d;
            ex_op_q   <= ex_op_d;
            ex_rd_q   <= ex_rd_d;
            ex_a_q    <= ex_a_d;
            ex_b_q    <= ex_b_d;
            result_q  <= result_d;
            z_flag_q  <= z_flag_d;
            rf_q      <= rf_d;
        end
    end

    // Program loads are blocked while running. A write in the same cycle as
    // start still lands, because state is not yet RUN on that edge.
    always_ff @(posedge clk) begin
        if (imem_we && (state_q != S_RUN)) begin
            imem_mem[imem_addr] <= imem_wdata;
        end
    end

    assign result = result_q;
    assign z_flag = z_flag_q;
    assign pc     = pc_q;

endmodule

// File: doc/nucore_pipe.md
NUCORE_PIPE -- requirements
Module: nucore_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width.
REQ-002 SHALL have parameter REG_AW, default 4, register-address width (2^REG_AW registers).
REQ-003 SHALL have parameter IMEM_AW, default 6, instruction-memory address width (2^IMEM_AW words).
REQ-004 SHALL define INST_W = 3 + 3*REG_AW + DATA_W; fields MSB->LSB: op[3], rd, ra, rb, imm[DATA_W].
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-006 imem_we  in  1  instruction-memory write strobe.
REQ-007 imem_addr  in  IMEM_AW  write address.
REQ-008 imem_wdata  in  INST_W  write data.
REQ-009 start  in  1  single-cycle pulse, begin execution at address 0.
REQ-010 result  out  DATA_W  last ALU/LOADI result.
REQ-011 z_flag  out  1  set when last ALU result == 0.
REQ-012 busy  out  1  high in RUN.
REQ-013 halted  out  1  high in HALTED.
REQ-014 pc  out  IMEM_AW  current fetch address.

Function
REQ-015 FSM states IDLE, RUN, HALTED; IDLE->RUN on start; RUN->HALTED when HALT reaches ID; HALTED->RUN on start; start in RUN ignored.
REQ-016 Entry to RUN SHALL set pc=0 and flush IF/ID/EX valid bits in the same edge.
REQ-017 Pipeline: IF (latch imem[pc], pc+1), ID (operand read, forwarding), EX (ALU, writeback); one instruction per cycle in RUN.
REQ-018 Opcodes: 000 NOP, 001 LOADI rd<=imm, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 HALT; ALU ops rd<=ra op rb.
REQ-019 Arithmetic modulo 2^DATA_W; carry/borrow discarded.
REQ-020 ID SHALL forward EX result when EX is valid, writes, and EX rd == ID ra (or rb); forwarding overrides register-file value.
REQ-021 Register file written at the end of EX; result updated on every valid LOADI/ALU in EX; z_flag updated only for opcodes 010-110.
REQ-022 NOP and HALT SHALL not write registers, result or z_flag.
REQ-023 On HALT in ID: instruction in IF squashed, fetch stops, pc holds, instruction already in EX completes.
REQ-024 pc SHALL wrap from 2^IMEM_AW-1 to 0.
REQ-025 imem_we honoured only in IDLE or HALTED; ignored in RUN.
REQ-026 Write to imem and start in same cycle: write SHALL occur; execution starts; write visible to fetches from next cycle.
REQ-027 First instruction result visible on result 3 cycles after the start edge.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE, pc=0, result=0, z_flag=0, busy=0, halted=0, all valid bits 0, all registers 0.
REQ-029 Instruction memory contents SHALL be unaffected by reset.
REQ-030 Reset asserted mid-RUN SHALL abort execution with no further writeback.

Configuration
REQ-031 Macro NUCORE_STEP_EN: when defined, adds input step (1 bit); in RUN all pipeline stages and pc advance only on cycles with step=1, otherwise hold; start/FSM unaffected.
REQ-032 Without NUCORE_STEP_EN: no step port; pipeline advances every RUN cycle.

Verification
REQ-033 Load LOADI r1,5; LOADI r2,5; SUB r3,r1,r2; HALT; start -> result 5,5,0; z_flag=1; halted=1; r3=0.
REQ-034 Back-to-back LOADI r1,7; ADD r2,r1,r1 -> result 14 (forwarding), z_flag=0.
REQ-035 DATA_W=8: LOADI r1,0xFF; LOADI r2,1; ADD r3,r1,r2 -> result 0x00, z_flag=1.
REQ-036 64 NOPs, no HALT -> pc wraps 63->0, busy stays 1, result stays 0.
REQ-037 reset_n low 2 cycles after start -> all outputs 0, state IDLE; imem retained; second start reruns program identically.
REQ-038 NUCORE_STEP_EN defined: step held 0 for 10 cycles after start -> pc stays 0; three step pulses -> first result appears after third pulse.
